// File: rtl/noc_pkg.sv
// Shared constants, state type and pointer helper for the mesh-router switch allocator.
package noc_pkg;

    localparam int NUM_PORTS = 5;
    localparam int CRED_W    = 3;
    localparam int PTR_W     = 3;

    // Fixed port index mapping.
    localparam int P_NORTH = 4;
    localparam int P_EAST  = 3;
    localparam int P_WEST  = 2;
    localparam int P_SOUTH = 1;
    localparam int P_LOCAL = 0;

    // Flit layout as seen by the input buffers.
    localparam int FLIT_W     = 17;
    localparam int FLIT_VALID = 16;

    typedef enum logic {ALLOC_IDLE, ALLOC_LOCKED} alloc_state_t;

    // Advance a port index by one, wrapping from the last port back to 0.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(NUM_PORTS - 1)) ? '0 : p + 1'b1;
    endfunction

endpackage

// File: rtl/switch_allocator_output_arbiter.sv
// One output port's wormhole arbiter: round-robin pick in IDLE, owner lock until tail.
module output_arbiter
    import noc_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_en,
    input  logic [NUM_PORTS-1:0] i_req,
    input  logic [NUM_PORTS-1:0] i_valid,
    input  logic [NUM_PORTS-1:0] i_tail,
    output logic [NUM_PORTS-1:0] o_grant,
    output logic                 o_lock,
    output logic [PTR_W-1:0]     o_owner
);

    alloc_state_t         r_state;
    logic [PTR_W-1:0]     r_owner;
    logic [PTR_W-1:0]     r_rr_ptr;

    alloc_state_t         w_state_nx;
    logic [PTR_W-1:0]     w_owner_nx;
    logic [PTR_W-1:0]     w_rr_nx;
    logic [NUM_PORTS-1:0] w_grant;
    logic                 w_found;
    logic [PTR_W-1:0]     w_win;
    logic [PTR_W-1:0]     w_cand;

    // State register: FSM state, packet owner and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ALLOC_IDLE;
            r_owner  <= '0;
            r_rr_ptr <= '0;
        end else begin
            r_state  <= w_state_nx;
            r_owner  <= w_owner_nx;
            r_rr_ptr <= w_rr_nx;
        end
    end

    // Round-robin search plus next-state and grant decode; grants are same-cycle.
    always_comb begin
        w_state_nx = r_state;
        w_owner_nx = r_owner;
        w_rr_nx    = r_rr_ptr;
        w_grant    = '0;
        w_found    = 1'b0;
        w_win      = '0;
        w_cand     = r_rr_ptr;

        for (int k = 0; k < NUM_PORTS; k++) begin
            if (!w_found && i_req[w_cand]) begin
                w_found = 1'b1;
                w_win   = w_cand;
            end
            w_cand = ptr_inc(w_cand);
        end

        case (r_state)
            ALLOC_IDLE: begin
                // With no credit the pointer is left alone so nobody loses a turn.
                if (w_found && i_en) begin
                    w_grant[w_win] = 1'b1;
                    if (!i_tail[w_win]) begin
                        w_state_nx = ALLOC_LOCKED;
                        w_owner_nx = w_win;
                    end else begin
                        w_rr_nx = ptr_inc(w_win);
                    end
                end
            end
            ALLOC_LOCKED: begin
                // The lock follows the owner's valid only; its route field is not consulted.
                if (i_valid[r_owner] && i_en) begin
                    w_grant[r_owner] = 1'b1;
                    if (i_tail[r_owner]) begin
                        w_state_nx = ALLOC_IDLE;
                        w_rr_nx    = ptr_inc(r_owner);
                    end
                end
            end
            default: w_state_nx = ALLOC_IDLE;
        endcase

        // Outputs are combinational from state, so they are forced quiet during reset.
        o_grant = rst ? '0 : w_grant;
        o_lock  = !rst && (r_state == ALLOC_LOCKED);
        o_owner = r_owner;
    end

endmodule

// File: rtl/switch_allocator.sv
// 5-port wormhole switch allocator: route decode, per-output arbiters, strobe reduction.
module switch_allocator
    import noc_pkg::*;
#(
    parameter logic [NUM_PORTS-1:0] PORT_EN = 5'b11111
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_PORTS-1:0]           valid_i,
    input  logic [NUM_PORTS-1:0]           tail_i,
    input  logic [NUM_PORTS*NUM_PORTS-1:0] route_i,
    input  logic [NUM_PORTS*CRED_W-1:0]    credit_all_i,
    output logic [NUM_PORTS*NUM_PORTS-1:0] grant_o,
    output logic [NUM_PORTS-1:0]           send_o,
    output logic [NUM_PORTS-1:0]           counter_minus_o,
    output logic [NUM_PORTS-1:0]           lock_o,
    output logic                           err_o
);

    logic [NUM_PORTS-1:0] w_route    [NUM_PORTS];
    logic [NUM_PORTS-1:0] w_req      [NUM_PORTS];
    logic [NUM_PORTS-1:0] w_grant    [NUM_PORTS];
    logic [PTR_W-1:0]     w_owner    [NUM_PORTS];
    logic [NUM_PORTS-1:0] w_route_ok;
    logic [NUM_PORTS-1:0] w_bad;
    logic [NUM_PORTS-1:0] w_lock;
    logic [NUM_PORTS-1:0] w_busy;
    logic [NUM_PORTS-1:0] w_send;

    // Per-input route decode: a route is usable only if one-hot and aimed at an enabled output.
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_in
        assign w_route[gi]    = route_i[gi*NUM_PORTS +: NUM_PORTS];
        assign w_route_ok[gi] = $onehot(w_route[gi]) && ((w_route[gi] & ~PORT_EN) == '0);
        assign w_bad[gi]      = valid_i[gi] && !w_route_ok[gi];
    end

    // Inputs already owning a locked output stay out of other outputs' searches,
    // which keeps send_o to at most one grant per input.
    always_comb begin
        w_busy = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            if (w_lock[o]) begin
                w_busy[w_owner[o]] = 1'b1;
            end
        end
    end

    // Request matrix: w_req[o][i] means input i's head flit wants output o.
    always_comb begin
        for (int o = 0; o < NUM_PORTS; o++) begin
            w_req[o] = '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                w_req[o][i] = valid_i[i] && w_route_ok[i] && w_route[i][o] && !w_busy[i];
            end
        end
    end

    for (genvar go = 0; go < NUM_PORTS; go++) begin : g_out
        output_arbiter u_arb (
            .clk     (clk),
            .rst     (rst),
            .i_en    (PORT_EN[go] && (credit_all_i[go*CRED_W +: CRED_W] != '0)),
            .i_req   (w_req[go]),
            .i_valid (valid_i),
            .i_tail  (tail_i),
            .o_grant (w_grant[go]),
            .o_lock  (w_lock[go]),
            .o_owner (w_owner[go])
        );
        assign grant_o[go*NUM_PORTS +: NUM_PORTS] = w_grant[go];
        assign counter_minus_o[go]                = |w_grant[go];
    end

    // Dequeue strobe per input: OR of that input's grants across all outputs.
    always_comb begin
        w_send = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            w_send = w_send | w_grant[o];
        end
    end

    assign send_o = w_send;
    assign lock_o = w_lock;
    assign err_o  = !rst && (|w_bad);

endmodule

// File: tb/tb_switch_allocator.sv
// Directed bench for switch_allocator with hand-computed expectations.
module tb_switch_allocator;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  valid, tail;
    logic [24:0] route;
    logic [14:0] credit;

    logic [24:0] grant_o, grant2;
    logic [4:0]  send_o, cm_o, lock_o, send2, cm2, lock2;
    logic        err_o, err2;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    switch_allocator dut (
        .clk(clk), .rst(rst), .valid_i(valid), .tail_i(tail), .route_i(route),
        .credit_all_i(credit), .grant_o(grant_o), .send_o(send_o),
        .counter_minus_o(cm_o), .lock_o(lock_o), .err_o(err_o)
    );

    switch_allocator #(.PORT_EN(5'b11011)) dut_edge (
        .clk(clk), .rst(rst), .valid_i(valid), .tail_i(tail), .route_i(route),
        .credit_all_i(credit), .grant_o(grant2), .send_o(send2),
        .counter_minus_o(cm2), .lock_o(lock2), .err_o(err2)
    );

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic set_in(input int i, input logic v, input logic t, input logic [4:0] r);
        valid[i]      = v;
        tail[i]       = t;
        route[5*i +: 5] = r;
    endtask

    task automatic to_neg();
        @(negedge clk);
    endtask

    task automatic to_next();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b1; valid = '0; tail = '0; route = '0; credit = {5{3'd3}};
        to_next();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; valid = '0; tail = '0; route = '0; credit = {5{3'd3}};
        // Reset cycle with a live request: outputs must be gated off.
        set_in(3, 1'b1, 1'b1, 5'b00001);
        to_neg();
        check_vec("rst_grant", grant_o, 0);
        check_vec("rst_send",  send_o, 0);
        check_vec("rst_cm",    cm_o, 0);
        check_vec("rst_lock",  lock_o, 0);
        check_vec("rst_err",   err_o, 0);
        to_next();
        rst = 1'b0;

        // Single flit E -> L.
        to_neg();
        check_vec("el_grant", grant_o, 32'h0000_0008);
        check_vec("el_send",  send_o, 5'b01000);
        check_vec("el_cm",    cm_o, 5'b00001);
        check_vec("el_lock",  lock_o[0], 0);
        to_next();

        // N and S contend for L with single flits every cycle.
        reset_dut();
        set_in(4, 1'b1, 1'b1, 5'b00001);
        set_in(1, 1'b1, 1'b1, 5'b00001);
        for (int c = 0; c < 4; c++) begin
            to_neg();
            check_vec("rr_grantL", grant_o[4:0], (c % 2 == 0) ? 5'b00010 : 5'b10000);
            check_vec("rr_cm",     cm_o, 5'b00001);
            to_next();
        end

        // 4-flit W -> E packet, local requests E from flit 2.
        reset_dut();
        set_in(2, 1'b1, 1'b0, 5'b01000);
        to_neg();
        check_vec("wh_hdr_grantE", grant_o[19:15], 5'b00100);
        check_vec("wh_hdr_lock",   lock_o[3], 0);
        to_next();
        set_in(0, 1'b1, 1'b1, 5'b01000);
        for (int f = 2; f <= 4; f++) begin
            if (f == 4) tail[2] = 1'b1;
            to_neg();
            check_vec("wh_body_grantE", grant_o[19:15], 5'b00100);
            check_vec("wh_body_lock",   lock_o[3], 1);
            check_vec("wh_body_send",   send_o, 5'b00100);
            to_next();
        end
        valid[2] = 1'b0;
        to_neg();
        check_vec("wh_local_grantE", grant_o[19:15], 5'b00001);
        check_vec("wh_local_lock",   lock_o[3], 0);
        to_next();

        // Credit stall mid-packet N -> E, then IDLE stall with no pointer skip.
        reset_dut();
        set_in(4, 1'b1, 1'b0, 5'b01000);
        to_neg();
        check_vec("cr_hdr_grantE", grant_o[19:15], 5'b10000);
        to_next();
        credit[11:9] = 3'd0;
        for (int c = 0; c < 3; c++) begin
            to_neg();
            check_vec("cr_stall_grantE", grant_o[19:15], 0);
            check_vec("cr_stall_cm",     cm_o, 0);
            check_vec("cr_stall_lock",   lock_o[3], 1);
            to_next();
        end
        credit[11:9] = 3'd1;
        to_neg();
        check_vec("cr_resume_grantE", grant_o[19:15], 5'b10000);
        check_vec("cr_resume_cm",     cm_o, 5'b01000);
        to_next();
        tail[4] = 1'b1;
        to_neg();
        check_vec("cr_tail_grantE", grant_o[19:15], 5'b10000);
        to_next();
        valid[4] = 1'b0;
        set_in(1, 1'b1, 1'b1, 5'b01000);
        set_in(2, 1'b1, 1'b1, 5'b01000);
        credit[11:9] = 3'd0;
        to_neg();
        check_vec("cr_idle_grantE", grant_o[19:15], 0);
        check_vec("cr_idle_lock",   lock_o[3], 0);
        to_next();
        credit[11:9] = 3'd3;
        to_neg();
        check_vec("cr_noskip_grantE", grant_o[19:15], 5'b00010);
        to_next();

        // Reset while E is locked.
        reset_dut();
        set_in(2, 1'b1, 1'b0, 5'b01000);
        to_neg();
        check_vec("mr_hdr_grantE", grant_o[19:15], 5'b00100);
        to_next();
        rst = 1'b1;
        to_neg();
        check_vec("mr_rst_grant", grant_o, 0);
        check_vec("mr_rst_lock",  lock_o, 0);
        check_vec("mr_rst_send",  send_o, 0);
        to_next();
        rst = 1'b0;
        valid[2] = 1'b0;
        set_in(4, 1'b1, 1'b0, 5'b01000);
        to_neg();
        check_vec("mr_post_lock",   lock_o, 0);
        check_vec("mr_post_grantE", grant_o[19:15], 5'b10000);
        to_next();

        // Disabled output and malformed routes.
        reset_dut();
        set_in(0, 1'b1, 1'b1, 5'b00100);
        to_neg();
        check_vec("pe_edge_grant", grant2, 0);
        check_vec("pe_edge_err",   err2, 1);
        check_vec("pe_full_grantW", grant_o[14:10], 5'b00001);
        check_vec("pe_full_err",    err_o, 0);
        to_next();
        route[4:0] = 5'b00110;
        to_neg();
        check_vec("pe_multi_err",   err_o, 1);
        check_vec("pe_multi_grant", grant_o, 0);
        check_vec("pe_multi_err2",  err2, 1);
        to_next();
        route[4:0] = 5'b00001;
        to_neg();
        check_vec("pe_ok_err",    err_o, 0);
        check_vec("pe_ok_err2",   err2, 0);
        check_vec("pe_ok_grantL", grant2[4:0], 5'b00001);
        to_next();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
